// File: rtl/monoc_blob_stats.sv
// Per-frame white-pixel count, bounding box and centroid of a binarized pixel stream.
// Result strobes N+1 cycles after the closing vsync edge; no backpressure, a frame ending mid-divide is dropped with overrun.
module monoc_blob_stats #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int MIN_PIXELS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               post_vsync,
  input  logic               post_href,
  input  logic               post_de,
  input  logic               monoc,
  output logic               stats_valid,
  output logic               found,
  output logic [X_W+Y_W-1:0] pixel_count,
  output logic [X_W-1:0]     box_x_min,
  output logic [X_W-1:0]     box_x_max,
  output logic [Y_W-1:0]     box_y_min,
  output logic [Y_W-1:0]     box_y_max,
  output logic [X_W-1:0]     cent_x,
  output logic [Y_W-1:0]     cent_y,
  output logic               overrun
);

  localparam int CW  = X_W + Y_W;
  localparam int SXW = 2 * X_W + Y_W;
  localparam int SYW = X_W + 2 * Y_W;
  localparam int N   = (SXW > SYW) ? SXW : SYW;
  localparam int IW  = $clog2(N + 1);
  localparam logic [X_W:0]    X_LIM   = (X_W + 1)'(H_ACTIVE);
  localparam logic [Y_W:0]    Y_LIM   = (Y_W + 1)'(V_ACTIVE);
  localparam logic [CW-1:0]   MIN_CNT = CW'(MIN_PIXELS);
  localparam logic [IW-1:0]   LAST_IT = IW'(N - 1);

  typedef enum logic {WAIT_SOF, ACCUM} acc_state_t;
  typedef enum logic [1:0] {IDLE, DIV, OUT} div_state_t;

  // Line framing comes from de alone; href is carried but not needed.
  logic unused_href;
  assign unused_href = post_href;

  logic vs_d, de_d;
  logic vs_rise, de_fall;
  assign vs_rise = post_vsync & ~vs_d;
  assign de_fall = ~post_de & de_d;

  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d <= 1'b0;
      de_d <= 1'b0;
      x    <= '0;
      y    <= '0;
    end else begin
      vs_d <= post_vsync;
      de_d <= post_de;
      if (vs_rise) begin
        x <= '0;
        y <= '0;
      end else if (de_fall) begin
        x <= '0;
        if (y != {Y_W{1'b1}}) y <= y + 1'b1;
      end else if (post_de && (x != {X_W{1'b1}})) begin
        x <= x + 1'b1;
      end
    end
  end

  acc_state_t acc_state, acc_next;
  div_state_t div_state, div_next;
  logic [IW-1:0] it_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_state <= WAIT_SOF;
      div_state <= IDLE;
    end else begin
      acc_state <= acc_next;
      div_state <= div_next;
    end
  end

  logic frame_end;
  assign frame_end = (acc_state == ACCUM) && vs_rise;

  always_comb begin
    acc_next = acc_state;
    if ((acc_state == WAIT_SOF) && vs_rise) acc_next = ACCUM;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      IDLE:    if (frame_end) div_next = DIV;
      DIV:     if (it_cnt == LAST_IT) div_next = OUT;
      default: div_next = IDLE;
    endcase
  end

  // Frame boundary wins over a coincident pixel.
  logic pix_hit;
  assign pix_hit = (acc_state == ACCUM) && !vs_rise && post_de && monoc &&
                   ({1'b0, x} < X_LIM) && ({1'b0, y} < Y_LIM);

  logic [CW-1:0]  cnt;
  logic [SXW-1:0] sum_x;
  logic [SYW-1:0] sum_y;
  logic [X_W-1:0] xmin, xmax;
  logic [Y_W-1:0] ymin, ymax;

  always_ff @(posedge clk) begin
    if (rst || vs_rise) begin
      cnt   <= '0;
      sum_x <= '0;
      sum_y <= '0;
      xmin  <= '0;
      xmax  <= '0;
      ymin  <= '0;
      ymax  <= '0;
    end else if (pix_hit) begin
      cnt   <= cnt + 1'b1;
      sum_x <= sum_x + SXW'(x);
      sum_y <= sum_y + SYW'(y);
      if (cnt == '0) begin
        xmin <= x;
        xmax <= x;
        ymin <= y;
        ymax <= y;
      end else begin
        if (x < xmin) xmin <= x;
        if (x > xmax) xmax <= x;
        if (y < ymin) ymin <= y;
        if (y > ymax) ymax <= y;
      end
    end
  end

  // Restoring dividers: dividend registers shift quotient bits in from the LSB.
  logic [CW-1:0]  d_cnt;
  logic [N-1:0]   d_dx, d_dy;
  logic [CW-1:0]  r_x, r_y;
  logic [X_W-1:0] s_xmin, s_xmax;
  logic [Y_W-1:0] s_ymin, s_ymax;
  logic [CW:0]    rx_sh, ry_sh;
  logic [CW-1:0]  rx_new, ry_new;
  logic           ge_x, ge_y, hit;

  always_comb begin
    rx_sh  = {r_x, d_dx[N-1]};
    ry_sh  = {r_y, d_dy[N-1]};
    ge_x   = rx_sh >= {1'b0, d_cnt};
    ge_y   = ry_sh >= {1'b0, d_cnt};
    rx_new = ge_x ? (rx_sh[CW-1:0] - d_cnt) : rx_sh[CW-1:0];
    ry_new = ge_y ? (ry_sh[CW-1:0] - d_cnt) : ry_sh[CW-1:0];
  end

  assign hit = d_cnt >= MIN_CNT;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_cnt       <= '0;
      d_dx        <= '0;
      d_dy        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      it_cnt      <= '0;
      s_xmin      <= '0;
      s_xmax      <= '0;
      s_ymin      <= '0;
      s_ymax      <= '0;
      stats_valid <= 1'b0;
      found       <= 1'b0;
      pixel_count <= '0;
      box_x_min   <= '0;
      box_x_max   <= '0;
      box_y_min   <= '0;
      box_y_max   <= '0;
      cent_x      <= '0;
      cent_y      <= '0;
      overrun     <= 1'b0;
    end else begin
      overrun     <= frame_end && (div_state != IDLE);
      stats_valid <= 1'b0;
      case (div_state)
        IDLE: begin
          if (frame_end) begin
            d_cnt  <= cnt;
            d_dx   <= N'(sum_x);
            d_dy   <= N'(sum_y);
            r_x    <= '0;
            r_y    <= '0;
            it_cnt <= '0;
            s_xmin <= xmin;
            s_xmax <= xmax;
            s_ymin <= ymin;
            s_ymax <= ymax;
          end
        end
        DIV: begin
          d_dx   <= {d_dx[N-2:0], ge_x};
          d_dy   <= {d_dy[N-2:0], ge_y};
          r_x    <= rx_new;
          r_y    <= ry_new;
          it_cnt <= it_cnt + 1'b1;
          if (it_cnt == LAST_IT) begin
            stats_valid <= 1'b1;
            pixel_count <= d_cnt;
            found       <= hit;
            box_x_min   <= hit ? s_xmin : '0;
            box_x_max   <= hit ? s_xmax : '0;
            box_y_min   <= hit ? s_ymin : '0;
            box_y_max   <= hit ? s_ymax : '0;
            // A zero count bypasses the quotient, which would be all ones.
            cent_x      <= (hit && (d_cnt != '0)) ? {d_dx[X_W-2:0], ge_x} : '0;
            cent_y      <= (hit && (d_cnt != '0)) ? {d_dy[Y_W-2:0], ge_y} : '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
